// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared encodings for the HI/LO multiply/divide engine: operation codes and FSM states.
package hilo_muldiv_unit_pkg;

   localparam logic [1:0] MULDIV_MULT  = 2'b00;
   localparam logic [1:0] MULDIV_MULTU = 2'b01;
   localparam logic [1:0] MULDIV_DIV   = 2'b10;
   localparam logic [1:0] MULDIV_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MUL  = 2'b01,
      ST_DIV  = 2'b10,
      ST_DONE = 2'b11
   } muldiv_state_t;

   function automatic logic op_is_signed(input logic [1:0] op);
      return (op == MULDIV_MULT) || (op == MULDIV_DIV);
   endfunction

   function automatic logic op_is_div(input logic [1:0] op);
      return (op == MULDIV_DIV) || (op == MULDIV_DIVU);
   endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Restoring divider datapath: one quotient bit per enabled step on unsigned magnitudes.
module muldiv_div_core #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH:0]   trial;

   always_comb begin
      rem_d = rem_q;
      quo_d = quo_q;
      dvs_d = dvs_q;
      // Borrow out of the top bit means the shifted remainder is below the divisor.
      trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
      if (load) begin
         rem_d = '0;
         quo_d = dividend;
         dvs_d = divisor;
      end else if (step) begin
         if (!trial[WIDTH]) begin
            rem_d = trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
         end else begin
            rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
      end else begin
         rem_q <= rem_d;
         quo_q <= quo_d;
         dvs_q <= dvs_d;
      end
   end

   assign quotient  = quo_q;
   assign remainder = rem_q;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle signed/unsigned multiply/divide engine producing HI/LO for the EX stage,
// holding the pipeline through stallreq while an operation is in flight.
module hilo_muldiv_unit
   import hilo_muldiv_unit_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int ITER_MUL = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             flush,
   output logic             stallreq,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] FULL_ITER = CW'(WIDTH);
   localparam logic [CW-1:0] ONE_ITER  = CW'(1);

   muldiv_state_t      state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   ma_q, ma_d;
   logic [WIDTH-1:0]   mb_q, mb_d;
   logic               neg_q, neg_d;
   logic               rneg_q, rneg_d;
   logic               div0_q, div0_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               done_q, done_d;

   logic               sgn;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     add_sum;
   logic [2*WIDTH-1:0] prod_fix;
   logic [CW-1:0]      mul_last, div_last;
   logic               div_load, div_step;
   logic [WIDTH-1:0]   div_quo, div_rem;

   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
      logic signed [WIDTH-1:0] sv;
      sv = v;
      return (is_signed && (sv < 0)) ? -v : v;
   endfunction

   function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic negate);
      return negate ? -v : v;
   endfunction

   assign sgn      = op_is_signed(op);
   assign mag_a    = magnitude(src_a, sgn);
   assign mag_b    = magnitude(src_b, sgn);
   assign prod_fix = neg_q ? -prod_q : prod_q;
   assign mul_last = (ITER_MUL != 0) ? FULL_ITER : ONE_ITER;
   assign div_last = div0_q ? ONE_ITER : FULL_ITER;

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      ma_d     = ma_q;
      mb_d     = mb_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      div0_d   = div0_q;
      cnt_d    = cnt_q;
      prod_d   = prod_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;
      div_load = 1'b0;
      div_step = 1'b0;
      add_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, ma_q} : '0);
      if (flush) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  a_d      = src_a;
                  ma_d     = mag_a;
                  mb_d     = mag_b;
                  neg_d    = sgn & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                  rneg_d   = sgn & src_a[WIDTH-1];
                  div0_d   = (src_b == '0);
                  cnt_d    = '0;
                  prod_d   = {{WIDTH{1'b0}}, mag_b};
                  div_load = 1'b1;
                  state_d  = op_is_div(op) ? ST_DIV : ST_MUL;
               end
            end
            ST_MUL: begin
               if (cnt_q == mul_last) begin
                  hi_d    = prod_fix[2*WIDTH-1:WIDTH];
                  lo_d    = prod_fix[WIDTH-1:0];
                  done_d  = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  cnt_d = cnt_q + ONE_ITER;
                  // Shift-add: multiplier bits leave the low half as product bits enter the top.
                  if (ITER_MUL != 0) prod_d = {add_sum, prod_q[WIDTH-1:1]};
                  else               prod_d = {{WIDTH{1'b0}}, ma_q} * {{WIDTH{1'b0}}, mb_q};
               end
            end
            ST_DIV: begin
               if (cnt_q == div_last) begin
                  hi_d    = div0_q ? a_q : apply_sign(div_rem, rneg_q);
                  lo_d    = div0_q ? '1  : apply_sign(div_quo, neg_q);
                  done_d  = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  cnt_d    = cnt_q + ONE_ITER;
                  div_step = ~div0_q;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         ma_q    <= '0;
         mb_q    <= '0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         div0_q  <= 1'b0;
         cnt_q   <= '0;
         prod_q  <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         ma_q    <= ma_d;
         mb_q    <= mb_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         div0_q  <= div0_d;
         cnt_q   <= cnt_d;
         prod_q  <= prod_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   muldiv_div_core #(.WIDTH(WIDTH)) u_div_core (
      .clk       (clk),
      .rst       (rst),
      .load      (div_load),
      .step      (div_step),
      .dividend  (mag_a),
      .divisor   (mag_b),
      .quotient  (div_quo),
      .remainder (div_rem)
   );

   // Combinational so the requesting instruction stalls in its own cycle.
   assign stallreq = (start & (state_q == ST_IDLE) & ~flush) |
                     (state_q == ST_MUL) | (state_q == ST_DIV);
   assign busy     = (state_q != ST_IDLE);
   assign done     = done_q;
   assign hi       = hi_q;
   assign lo       = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: iterative (s) and single-cycle multiply (f) instances share stimulus.
module tb_hilo_muldiv_unit;
   import hilo_muldiv_unit_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         flush = 1'b0;
   logic [1:0]   op = 2'b00;
   logic [W-1:0] src_a = '0;
   logic [W-1:0] src_b = '0;

   logic         stall_s, busy_s, done_s, stall_f, busy_f, done_f;
   logic [W-1:0] hi_s, lo_s, hi_f, lo_f;

   int checks = 0;
   int errors = 0;
   int done_cnt_s = 0, done_cnt_f = 0;
   int exp_cnt_s = 0, exp_cnt_f = 0;
   logic [2*W-1:0] q_s[$];
   logic [2*W-1:0] q_f[$];
   logic [2*W-1:0] last_exp = '0;

   always #5 clk = ~clk;

   hilo_muldiv_unit #(.WIDTH(W), .ITER_MUL(1)) dut_s (
      .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
      .flush(flush), .stallreq(stall_s), .busy(busy_s), .done(done_s), .hi(hi_s), .lo(lo_s));

   hilo_muldiv_unit #(.WIDTH(W), .ITER_MUL(0)) dut_f (
      .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
      .flush(flush), .stallreq(stall_f), .busy(busy_f), .done(done_f), .hi(hi_f), .lo(lo_f));

   task automatic check_eq(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   function automatic logic [2*W-1:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      logic signed [2*W-1:0] sa, sb, sp;
      logic signed [W-1:0]   qa, qb;
      logic [W-1:0]          q, r;
      sa = {{W{a[W-1]}}, a};
      sb = {{W{b[W-1]}}, b};
      qa = a;
      qb = b;
      case (o)
         MULDIV_MULT: begin
            sp = sa * sb;
            return sp;
         end
         MULDIV_MULTU: return {{W{1'b0}}, a} * {{W{1'b0}}, b};
         MULDIV_DIV: begin
            if (b == '0) return {a, {W{1'b1}}};
            if (a == {1'b1, {(W-1){1'b0}}} && b == {W{1'b1}}) return {{W{1'b0}}, a};
            q = qa / qb;
            r = qa % qb;
            return {r, q};
         end
         default: begin
            if (b == '0) return {a, {W{1'b1}}};
            return {a % b, a / b};
         end
      endcase
   endfunction

   // Scoreboard: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && done_s) begin
         done_cnt_s++;
         if (q_s.size() == 0) check_eq("s.spurious_done", 1, 0);
         else check_eq("s.hilo", {hi_s, lo_s}, q_s.pop_front());
      end
      if (!rst && done_f) begin
         done_cnt_f++;
         if (q_f.size() == 0) check_eq("f.spurious_done", 1, 0);
         else check_eq("f.hilo", {hi_f, lo_f}, q_f.pop_front());
      end
   end

   task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int poke_at);
      logic [2*W-1:0] e;
      int lat_s, lat_f, got_s, got_f;
      bit stall_ok_s, stall_ok_f;
      e = model(o, a, b);
      lat_s = (o[1] && b == '0) ? 2 : W + 1;
      lat_f = (o[1] && b != '0) ? W + 1 : 2;
      @(negedge clk);
      op = o; src_a = a; src_b = b; start = 1'b1;
      q_s.push_back(e); q_f.push_back(e);
      exp_cnt_s++; exp_cnt_f++;
      last_exp = e;
      #1 check_eq({tag, ".stall_k"}, {62'b0, stall_s, stall_f}, 64'd3);
      got_s = -1; got_f = -1; stall_ok_s = 1; stall_ok_f = 1;
      for (int n = 0; n < 3 * W && (got_s < 0 || got_f < 0); n++) begin
         @(posedge clk);
         @(negedge clk);
         start = 1'b0;
         if (n == poke_at) begin
            start = 1'b1; op = MULDIV_MULTU; src_a = 32'h0000_0003; src_b = 32'h0000_0005;
         end
         #1;
         if (got_s < 0) begin
            if (done_s) begin got_s = n; if (stall_s) stall_ok_s = 0; end
            else if (!stall_s) stall_ok_s = 0;
         end
         if (got_f < 0) begin
            if (done_f) begin got_f = n; if (stall_f) stall_ok_f = 0; end
            else if (!stall_f) stall_ok_f = 0;
         end
      end
      start = 1'b0;
      check_eq({tag, ".lat_s"}, 64'(got_s), 64'(lat_s));
      check_eq({tag, ".lat_f"}, 64'(got_f), 64'(lat_f));
      check_eq({tag, ".stall_s"}, 64'(stall_ok_s), 64'd1);
      check_eq({tag, ".stall_f"}, 64'(stall_ok_f), 64'd1);
   endtask

   initial begin
      logic [1:0] ro;
      logic [W-1:0] ra, rb;
      #12;
      check_eq("rst.hilo_s", {hi_s, lo_s}, '0);
      check_eq("rst.hilo_f", {hi_f, lo_f}, '0);
      check_eq("rst.ctrl", {60'b0, busy_s, done_s, busy_f, done_f}, '0);
      @(negedge clk);
      rst = 1'b0;
      #1 check_eq("rst.stall", {62'b0, stall_s, stall_f}, '0);

      run_op("multu", MULDIV_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, -1);
      run_op("mult",  MULDIV_MULT,  32'hFFFF_FFFF, 32'h0000_0002, -1);
      run_op("div_neg", MULDIV_DIV, 32'hFFFF_FFF9, 32'h0000_0002, -1);
      run_op("divu",  MULDIV_DIVU,  32'd100, 32'd7, -1);
      run_op("div_ovf", MULDIV_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1);
      run_op("divu_z", MULDIV_DIVU, 32'h1234_5678, 32'h0000_0000, -1);
      run_op("div_z",  MULDIV_DIV,  32'h8765_4321, 32'h0000_0000, -1);
      run_op("mult_mn", MULDIV_MULT, 32'h8000_0000, 32'h8000_0000, -1);

      for (int i = 0; i < 8; i++) begin
         ro = 2'($urandom_range(0, 3));
         ra = $urandom;
         rb = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
         run_op("rand", ro, ra, rb, -1);
      end

      // A second start while busy is neither launched nor queued.
      run_op("poke", MULDIV_DIVU, 32'd1000, 32'd9, 5);

      // Flush at cycle k+10 of a divide: back to IDLE, no done, hi/lo untouched.
      @(negedge clk);
      op = MULDIV_DIV; src_a = 32'h0000_4000; src_b = 32'h0000_0003; start = 1'b1;
      for (int n = 0; n < 10; n++) begin
         @(posedge clk);
         @(negedge clk);
         start = 1'b0;
      end
      flush = 1'b1;
      @(posedge clk);
      @(negedge clk);
      flush = 1'b0;
      #1;
      check_eq("flush.busy", {62'b0, busy_s, busy_f}, '0);
      check_eq("flush.done", {62'b0, done_s, done_f}, '0);
      check_eq("flush.hilo_s", {hi_s, lo_s}, last_exp);
      check_eq("flush.hilo_f", {hi_f, lo_f}, last_exp);
      run_op("after_flush", MULDIV_DIV, 32'hFFFF_FF00, 32'h0000_0007, -1);

      // Async reset in the middle of an iterative multiply.
      @(negedge clk);
      op = MULDIV_MULTU; src_a = 32'hDEAD_BEEF; src_b = 32'h0000_1234; start = 1'b1;
      q_f.push_back(model(MULDIV_MULTU, 32'hDEAD_BEEF, 32'h0000_1234));
      exp_cnt_f++;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check_eq("arst.hilo_s", {hi_s, lo_s}, '0);
      check_eq("arst.hilo_f", {hi_f, lo_f}, '0);
      check_eq("arst.ctrl", {60'b0, busy_s, stall_s, busy_f, stall_f}, '0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2 * W) @(negedge clk);
      #1 check_eq("arst.idle", {62'b0, busy_s, busy_f}, '0);

      check_eq("done_count_s", 64'(done_cnt_s), 64'(exp_cnt_s));
      check_eq("done_count_f", 64'(done_cnt_f), 64'(exp_cnt_f));
      check_eq("queue_empty", 64'(q_s.size() + q_f.size()), '0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
